demux1_4_tdm: RTL and testbench

Time-division demultiplexer: the receive end of a 4-slot serial link whose transmit end is the 4-to-1 multiplexer driven by a slot counter. Accepts one sample per enabled cycle on a single lane, aligns to a start-of-frame marker, and re-assembles four samples into registered parallel outputs `a`, `b`, `c`, `d` with a one-cycle `valid` pulse. Sits in the ALU datapath next to the mux as its counterpart for serialised operand/result transfer.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux1_4_tdm_dec2_4.sv | 18 +
 rtl/demux1_4_tdm.sv | 126 ++++++++++++
 tb/tb_demux1_4_tdm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and frame geometry for the 1:4 TDM demultiplexer.
// Define DEMUX_PARITY_EN to append an even-parity slot to every frame.
package demux_pkg;

`ifdef DEMUX_PARITY_EN
    localparam int unsigned N_SLOTS = 5;
`else
    localparam int unsigned N_SLOTS = 4;
`endif

    localparam int unsigned SLOT_W = $clog2(N_SLOTS);

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RECV = 1'b1;

endpackage

// File: rtl/demux1_4_tdm_dec2_4.sv
// Slot-index decoder: one-hot write enable for the slot being received, gated by en.
module dec2_4 #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic [SW-1:0] sel_i,
    input  logic          en_i,
    output logic [N-1:0]  we_o
);

    always_comb begin
        we_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (en_i && (sel_i == SW'(i))) we_o[i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1_4_tdm.sv
// Receive end of the 4-slot serial link: aligns on sof and rebuilds a..d from shadow registers.
// Build option DEMUX_PARITY_EN adds a fifth, even-parity slot checked before outputs update.
module demux1_4_tdm
    import demux_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      in,
    input  logic              en,
    input  logic              sof,
    output logic [W-1:0]      a,
    output logic [W-1:0]      b,
    output logic [W-1:0]      c,
    output logic [W-1:0]      d,
    output logic              valid,
    output logic [SLOT_W-1:0] S,
    output logic              err
);

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   s_q, s_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic                valid_q, valid_d, err_q, err_d;
    logic [W-1:0]        shadow_q [N_SLOTS-1];

    logic [N_SLOTS-1:0]  we;
    logic [N_SLOTS-2:0]  sh_we;
    logic                rx, frame_done;

    assign rx = (state_q == RECV);

    // A sof always restarts at slot 0, so the decoder sees index 0 whenever sof is up.
    dec2_4 #(
        .N  (N_SLOTS),
        .SW (SLOT_W)
    ) u_dec (
        .sel_i (sof ? '0 : s_q),
        .en_i  (en),
        .we_o  (we)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_SLOTS - 1; i++) begin
            sh_we[i] = we[i] & (sof | rx);
        end
    end

    assign frame_done = we[N_SLOTS-1] & rx;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            if (sof) begin
                state_d = RECV;
                s_d     = SLOT_W'(1);
                err_d   = rx;
            end else if (frame_done) begin
                state_d = IDLE;
                s_d     = '0;
`ifdef DEMUX_PARITY_EN
                if (^{shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3], in} == 1'b0) begin
                    a_d     = shadow_q[0];
                    b_d     = shadow_q[1];
                    c_d     = shadow_q[2];
                    d_d     = shadow_q[3];
                    valid_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
`else
                a_d     = shadow_q[0];
                b_d     = shadow_q[1];
                c_d     = shadow_q[2];
                d_d     = in;
                valid_d = 1'b1;
`endif
            end else if (rx) begin
                s_d = s_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < N_SLOTS - 1; i++) shadow_q[i] <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < N_SLOTS - 1; i++) begin
                if (sh_we[i]) shadow_q[i] <= in;
            end
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign c     = c_q;
    assign d     = d_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign S     = s_q;

endmodule

// File: tb/tb_demux1_4_tdm.sv
// Directed self-checking bench for demux1_4_tdm (W=1); also covers the DEMUX_PARITY_EN build.
module tb_demux1_4_tdm;
    import demux_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [0:0]        in;
    logic              en, sof;
    logic [0:0]        a, b, c, d;
    logic              valid, err;
    logic [SLOT_W-1:0] S;

    int unsigned total = 0;
    int unsigned bad   = 0;

    demux1_4_tdm #(.W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .en    (en),
        .sof   (sof),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .valid (valid),
        .S     (S),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic s, input logic v);
        en  = 1'b1;
        sof = s;
        in  = v;
        tick();
        en  = 1'b0;
        sof = 1'b0;
    endtask

    task automatic gap(input int unsigned n);
        en = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    // Sends the slot-3 sample (abcd[0]) plus, in parity builds, the matching even-parity slot.
    task automatic tail(input logic [3:0] abcd);
        acc(1'b0, abcd[0]);
`ifdef DEMUX_PARITY_EN
        acc(1'b0, ^abcd);
`endif
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, a, b, c, d};
    endfunction

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sof   = 1'b0;
        in    = 1'b0;
        #12;
        chk("rst_out",   outs(),     32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err",   32'(err),   32'h0);
        chk("rst_S",     32'(S),     32'h0);
        rst_n = 1'b1;
        tick();

        // discarded sample in IDLE, and en=0 ignores sof
        acc(1'b0, 1'b1);
        chk("idle_discard_S", 32'(S), 32'h0);
        sof = 1'b1; in = 1'b1;
        gap(1);
        sof = 1'b0;
        chk("idle_en0_S", 32'(S), 32'h0);

        // basic frame 1,0,1,1
        acc(1'b1, 1'b1);
        chk("f1_S1", 32'(S), 32'h1);
        chk("f1_nv", 32'(valid), 32'h0);
        acc(1'b0, 1'b0);
        chk("f1_S2", 32'(S), 32'h2);
        acc(1'b0, 1'b1);
        chk("f1_S3", 32'(S), 32'h3);
        chk("f1_out_hold", outs(), 32'h0);
        tail(4'b1011);
        chk("f1_valid", 32'(valid), 32'h1);
        chk("f1_out",   outs(),     32'hb);
        chk("f1_S0",    32'(S),     32'h0);
        gap(1);
        chk("f1_valid_clr", 32'(valid), 32'h0);
        chk("f1_out_keep",  outs(),     32'hb);

        // gap of 3 between slots 1 and 2, frame 0,1,1,1 so outputs visibly change
        acc(1'b1, 1'b0);
        acc(1'b0, 1'b1);
        gap(3);
        chk("gap_S", 32'(S), 32'h2);
        chk("gap_nv", 32'(valid), 32'h0);
        acc(1'b0, 1'b1);
        tail(4'b0111);
        chk("gap_valid", 32'(valid), 32'h1);
        chk("gap_out",   outs(),     32'h7);

        // sof mid-frame aborts partial 1,1
        acc(1'b1, 1'b1);
        acc(1'b0, 1'b1);
        acc(1'b1, 1'b0);
        chk("ab_err",   32'(err),   32'h1);
        chk("ab_nv",    32'(valid), 32'h0);
        chk("ab_S",     32'(S),     32'h1);
        chk("ab_keep",  outs(),     32'h7);
        acc(1'b0, 1'b0);
        chk("ab_err_clr", 32'(err), 32'h0);
        acc(1'b0, 1'b1);
        tail(4'b0010);
        chk("ab_valid", 32'(valid), 32'h1);
        chk("ab_out",   outs(),     32'h2);
        chk("ab_err0",  32'(err),   32'h0);

        // back-to-back frames 1,1,1,1 then 0,1,0,1
        acc(1'b1, 1'b1);
        acc(1'b0, 1'b1);
        acc(1'b0, 1'b1);
        tail(4'b1111);
        chk("bb1_valid", 32'(valid), 32'h1);
        chk("bb1_out",   outs(),     32'hf);
        acc(1'b1, 1'b0);
        chk("bb2_nv",   32'(valid), 32'h0);
        chk("bb2_S",    32'(S),     32'h1);
        chk("bb2_keep", outs(),     32'hf);
        acc(1'b0, 1'b1);
        acc(1'b0, 1'b0);
        tail(4'b0101);
        chk("bb2_valid", 32'(valid), 32'h1);
        chk("bb2_out",   outs(),     32'h5);

        // asynchronous reset mid-frame
        acc(1'b1, 1'b1);
        acc(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out", outs(),   32'h0);
        chk("ar_S",   32'(S),   32'h0);
        rst_n = 1'b1;
        acc(1'b0, 1'b1);
        chk("ar_idle_S", 32'(S), 32'h0);
        acc(1'b1, 1'b0);
        acc(1'b0, 1'b1);
        acc(1'b0, 1'b1);
        tail(4'b0110);
        chk("ar_valid", 32'(valid), 32'h1);
        chk("ar_out2",  outs(),     32'h6);

`ifdef DEMUX_PARITY_EN
        // good parity then bad parity on 1,0,1,1
        acc(1'b1, 1'b1);
        acc(1'b0, 1'b0);
        acc(1'b0, 1'b1);
        acc(1'b0, 1'b1);
        chk("par_S4", 32'(S), 32'h4);
        acc(1'b0, 1'b1);
        chk("par_ok_valid", 32'(valid), 32'h1);
        chk("par_ok_out",   outs(),     32'hb);
        acc(1'b1, 1'b0);
        acc(1'b0, 1'b1);
        acc(1'b0, 1'b1);
        acc(1'b0, 1'b0);
        acc(1'b0, 1'b1);
        chk("par_bad_err",   32'(err),   32'h1);
        chk("par_bad_nv",    32'(valid), 32'h0);
        chk("par_bad_keep",  outs(),     32'hb);
        chk("par_bad_S",     32'(S),     32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
